// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared widths and instruction record for the issue queue
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 7
`endif

package instr_pkg;
  localparam int REG_WIDTH = `REG_WIDTH;
  localparam int OP_WIDTH  = `OP_WIDTH;
  localparam int NUM_REGS  = 2 ** REG_WIDTH;

  typedef struct packed {
    logic [REG_WIDTH-1:0] rs0;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rd;
    logic [OP_WIDTH-1:0]  opcode;
  } instr_t;
endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - in-order instruction FIFO with combinational head view
module instr_fifo
  import instr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  instr_t                   push_data,
  output instr_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  instr_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; validity is tracked by pointers and count only.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - in-order issue queue with register scoreboard
module instr_issue_queue #(
  parameter int REG_WIDTH = instr_pkg::REG_WIDTH,
  parameter int OP_WIDTH  = instr_pkg::OP_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [REG_WIDTH-1:0]    in_rs0,
  input  logic [REG_WIDTH-1:0]    in_rs1,
  input  logic [REG_WIDTH-1:0]    in_rd,
  input  logic [OP_WIDTH-1:0]     in_opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_WIDTH-1:0]    out_rs0,
  output logic [REG_WIDTH-1:0]    out_rs1,
  output logic [REG_WIDTH-1:0]    out_rd,
  output logic [OP_WIDTH-1:0]     out_opcode,
  input  logic                    wb_valid,
  input  logic [REG_WIDTH-1:0]    wb_rd,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    stall,
  output logic                    overflow
);
  import instr_pkg::*;

  localparam int NREG = 2 ** REG_WIDTH;

  instr_t            in_instr, head;
  logic              full, empty, hazard, fire, push;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              overflow_q, overflow_d;

  assign in_instr = '{rs0: in_rs0, rs1: in_rs1, rd: in_rd, opcode: in_opcode};

  // Only the registered busy vector is consulted; writebacks are not bypassed.
  assign hazard    = busy_q[head.rs0] | busy_q[head.rs1] | busy_q[head.rd];
  assign out_valid = !empty && !hazard;
  assign stall     = !empty && hazard;
  assign fire      = out_valid && out_ready;
  assign push      = in_valid && (!full || fire);

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (fire),
    .push_data (in_instr),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Clear first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (fire && (head.rd != '0)) busy_d[head.rd] = 1'b1;
    busy_d[0] = 1'b0;
    overflow_d = overflow_q | (in_valid && full && !fire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow   = overflow_q;
  assign out_rs0    = head.rs0;
  assign out_rs1    = head.rs1;
  assign out_rd     = head.rd;
  assign out_opcode = head.opcode;
endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Buffers the decoded instruction stream (valid, rs0, rs1, rd, opcode) and issues it in order to the execution unit. The upstream port has no backpressure, so every valid beat is captured or counted as an overflow. A register scoreboard holds the head instruction while any source or destination register has a write outstanding. Writeback from the execution unit clears the scoreboard.

## Interface
Parameters:
- REG_WIDTH, default `REG_WIDTH` (5): register index width; 2**REG_WIDTH architectural registers.
- OP_WIDTH, default `OP_WIDTH` (7): opcode width.
- DEPTH, default 4: queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- in_valid  input  1  instruction present this cycle; no ready exists on this side.
- in_rs0, in_rs1  input  REG_WIDTH each  source register indices.
- in_rd  input  REG_WIDTH  destination register index.
- in_opcode  input  OP_WIDTH  opcode; carried through, not decoded.
- out_valid  output  1  head instruction is issuable.
- out_ready  input  1  execution unit accepts; issue fires when out_valid && out_ready.
- out_rs0, out_rs1, out_rd  output  REG_WIDTH  head fields.
- out_opcode  output  OP_WIDTH  head opcode.
- wb_valid  input  1  writeback completes this cycle.
- wb_rd  input  REG_WIDTH  register being written back.
- count  output  $clog2(DEPTH)+1  current occupancy.
- stall  output  1  queue not empty and head blocked by a hazard.
- overflow  output  1  sticky; set when a valid beat is dropped.

## Operation
- Push: in_valid and (not full, or an issue fires in the same cycle) writes the beat at the tail. If in_valid arrives while full and no issue fires, the beat is dropped and overflow is set. overflow stays set until reset.
- Scoreboard: `busy` holds one bit per register. Register 0 is never busy: writes to bit 0 are ignored, and bit 0 always reads 0.
- Hazard: head.rs0, head.rs1 or head.rd is busy. The rd check covers WAW.
- The hazard check uses the registered busy vector only. A writeback is not bypassed into the same cycle's check.
- out_valid = !empty && !hazard. stall = !empty && hazard.
- Output fields present the head entry continuously, and are don't-care when empty.
- On issue fire: pop the head, and set busy[head.rd] when rd != 0.
- On wb_valid: clear busy[wb_rd].
- If the same register is set and cleared in one cycle, set wins.
- A writeback to a register that is not busy has no effect.
- Stability: once out_valid rises, it and the output fields hold until fire. A hazard cannot re-arise while the head waits, because busy bits are set only on fire.
- Reset values: out_valid 0, stall 0, count 0, overflow 0, busy all 0, queue empty, pointers 0. The output fields have no reset requirement.
- Reset mid-operation: all queued instructions and busy bits are discarded immediately (asynchronous). Outputs reach their reset values without waiting for a clock edge.

## Timing
- Push to issue: a beat pushed at edge N into an empty queue, hazard-free, gives out_valid=1 in the cycle after edge N. There is no same-cycle bypass, so latency is 1 cycle.
- Issue to dependent issue: an instruction with rd=r issues at edge N. A follower reading r waits until a wb of r is sampled at edge M. The follower's out_valid rises in the cycle after edge M, giving a minimum 1-cycle bubble after writeback.
- Sustained throughput: 1 instruction per cycle when hazard-free and out_ready=1.
- count updates at the edge: +1 for push only, -1 for pop only, unchanged for push and pop together or for neither.
- Pointers wrap modulo DEPTH. full = (count == DEPTH).

## Structure
- Package `instr_pkg` holds:
  - REG_WIDTH and OP_WIDTH localparams, matching the `REG_WIDTH`/`OP_WIDTH` macros;
  - `instr_t` packed struct {rs0, rs1, rd, opcode};
  - NUM_REGS constant.
- Sub-module `instr_fifo`: a synchronous FIFO of `instr_t`, DEPTH entries, with asynchronous active-high reset. It provides push, pop, head, count, full and empty.
- The scoreboard, hazard logic and overflow flag live in `instr_issue_queue`.

## Test plan
- Basic flow: reset, then push {rs0=1, rs1=2, rd=3} with out_ready=1. Expect out_valid in the next cycle with those fields. After fire, expect busy[3]=1 and count returning to 0.
- RAW stall: push rd=5, then a second beat with rs0=5. The second beat must hold out_valid=0 and stall=1. Pulse wb_valid with wb_rd=5 at edge M. Expect the second beat's out_valid in the cycle after M.
- x0 exemption: push 3 instructions with rd=0 and rs0=0 back-to-back, out_ready=1. Expect all 3 to issue on consecutive cycles with no stall.
- Full/overflow: hold out_ready=0 and push 5 beats with DEPTH=4. Expect count=4 and overflow=1, and the 5th beat absent from the output. Then push while full with out_ready=1 and no hazard: the push must be accepted and count must stay 4.
- Simultaneous set/clear: with busy[7]=1 from an earlier issue, issue a new rd=7 instruction at the edge where wb_rd=7 arrives. Arrange this by clearing the first instruction via writeback one cycle earlier and then reasserting. Expect busy[7]=1 after that edge.
- Reset mid-operation: with 3 entries queued and busy bits set, assert reset between edges. Expect out_valid=0, count=0 and overflow=0 immediately. After release, a push with rs0 at a previously busy register issues with no stall.
